program_counter_stack: RTL

Parametrised successor to the 4-bit SAP program counter for the 8BitCpu datapath.
- Holds the PC, increments it, loads jump targets from the bus, and drives the PC back onto the bus through a registered output enable.
- Adds a hardware call/return stack with sticky overflow/underflow flags, and a wrap pulse.
- Sits between the control sequencer (ld/cp/call/ret/ep) and the shared bus.

---
 rtl/program_counter_stack_if.sv | 48 ++++
 rtl/program_counter_stack.sv | 120 ++++++++++++
 2 files changed

// File: rtl/program_counter_stack_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : program_counter_stack_if                                         |
// | Brief   : Sequencer/bus-side signal bundle for program_counter_stack.      |
// |           Optional macro PC_RELJUMP_EN adds the rel request line.          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface program_counter_stack_if #(
    parameter int WIDTH       = 4,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] din;
    logic             ld;
    logic             cp;
    logic             call;
    logic             ret;
    logic             ep;
    logic             flag_clr;
`ifdef PC_RELJUMP_EN
    logic             rel;
`endif
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] bus_out;
    logic             bus_oe;
    logic [SP_W-1:0]  sp_out;
    logic             wrap;
    logic             stk_ovf;
    logic             stk_unf;

    modport master (
`ifdef PC_RELJUMP_EN
        output rel,
`endif
        output din, ld, cp, call, ret, ep, flag_clr,
        input  pc_out, bus_out, bus_oe, sp_out, wrap, stk_ovf, stk_unf
    );

    modport slave (
`ifdef PC_RELJUMP_EN
        input  rel,
`endif
        input  din, ld, cp, call, ret, ep, flag_clr,
        output pc_out, bus_out, bus_oe, sp_out, wrap, stk_ovf, stk_unf
    );
endinterface
`default_nettype wire

// File: rtl/program_counter_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : program_counter_stack                                            |
// | Brief   : Program counter with call/return stack, sticky stack-fault flags |
// |           and registered bus drive. Macro PC_RELJUMP_EN adds relative jump.|
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module program_counter_stack #(
    parameter int WIDTH       = 4,
    parameter int STACK_DEPTH = 4,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    program_counter_stack_if.slave pc_if
);
    localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [WIDTH-1:0] pc_q,      pc_d;
    logic [SP_W-1:0]  sp_q,      sp_d;
    logic             wrap_q,    wrap_d;
    logic             ovf_q,     ovf_d;
    logic             unf_q,     unf_d;
    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic             bus_oe_q,  bus_oe_d;

    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic             push_en;
    logic             ovf_set;
    logic             unf_set;
    logic [WIDTH-1:0] pc_inc;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;

    assign pc_inc   = pc_q + WIDTH'(1);
    assign push_idx = IDX_W'(sp_q);
    assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

    // Single priority chain: only the winning request touches pc/sp/stack.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        wrap_d  = 1'b0;
        push_en = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (pc_if.ld) begin
            pc_d = pc_if.din;
        end
`ifdef PC_RELJUMP_EN
        else if (pc_if.rel) begin
            pc_d = pc_q + pc_if.din;
        end
`endif
        else if (pc_if.call) begin
            if (sp_q != SP_FULL) begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                pc_d    = pc_if.din;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (pc_if.ret) begin
            if (sp_q != '0) begin
                pc_d = stack_q[pop_idx];
                sp_d = sp_q - SP_W'(1);
            end else begin
                unf_set = 1'b1;
            end
        end else if (pc_if.cp) begin
            pc_d   = pc_inc;
            wrap_d = &pc_q;
        end
    end

    // A fault in the same cycle as flag_clr keeps the flag set.
    always_comb begin
        ovf_d     = ovf_set | (ovf_q & ~pc_if.flag_clr);
        unf_d     = unf_set | (unf_q & ~pc_if.flag_clr);
        bus_oe_d  = pc_if.ep;
        bus_out_d = pc_if.ep ? pc_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= '0;
            sp_q      <= '0;
            wrap_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            bus_out_q <= '0;
            bus_oe_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            wrap_q    <= wrap_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
        end
    end

    // Return-address storage is not reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (rst_n && push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc_if.pc_out  = pc_q;
    assign pc_if.sp_out  = sp_q;
    assign pc_if.wrap    = wrap_q;
    assign pc_if.stk_ovf = ovf_q;
    assign pc_if.stk_unf = unf_q;
    assign pc_if.bus_out = bus_out_q;
    assign pc_if.bus_oe  = bus_oe_q;
endmodule
`default_nettype wire
